ofdm_fft_frame_buffer: RTL and testbench

Parametrised ping-pong input framer placed in front of myFFT in the OFDM receive chain.
- Accepts a gapped complex sample stream and aligns it to OFDM symbols from a start-of-frame marker.
- Strips the cyclic prefix and stores NFFT samples per symbol in one of two banks.
- Streams each full bank out in natural or bit-reversed order under a valid/ready handshake.

---
 rtl/ofdm_fft_frame_buffer_if.sv | 31 +++
 rtl/ofdm_fft_frame_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_ofdm_fft_frame_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_fft_frame_buffer_if.sv
// Sample-stream bundle of the OFDM FFT input framer: gapped input side plus
// valid/ready output side. The framer attaches through the slave modport.
interface ofdm_fft_frame_buffer_if #(
   parameter int SIZE_BUFFER = 8,
   parameter int DATA_SIZE   = 16
);
   logic                   valid;
   logic                   sof;
   logic [DATA_SIZE-1:0]   data_in_i;
   logic [DATA_SIZE-1:0]   data_in_q;
   logic [DATA_SIZE-1:0]   data_out_i;
   logic [DATA_SIZE-1:0]   data_out_q;
   logic                   valid_out;
   logic                   flag_ready_recive;
   logic                   last_out;
   logic [SIZE_BUFFER-1:0] index_out;
   logic                   flag_wayt_data;
   logic                   overflow;

   modport master (
      output valid, sof, data_in_i, data_in_q, flag_ready_recive,
      input  data_out_i, data_out_q, valid_out, last_out, index_out,
             flag_wayt_data, overflow
   );

   modport slave (
      input  valid, sof, data_in_i, data_in_q, flag_ready_recive,
      output data_out_i, data_out_q, valid_out, last_out, index_out,
             flag_wayt_data, overflow
   );
endinterface

// File: rtl/ofdm_fft_frame_buffer.sv
// Ping-pong OFDM symbol framer in front of the FFT: strips the cyclic prefix,
// fills one of two banks and streams full banks out in natural or bit-reversed order.
module ofdm_fft_frame_buffer #(
   parameter int    SIZE_BUFFER = 8,
   parameter int    DATA_SIZE   = 16,
   parameter int    CP_LEN      = 0,
   parameter string ORDER       = "natural"
) (
   input logic                    clk,
   input logic                    reset,
   ofdm_fft_frame_buffer_if.slave bus
);
   localparam int              NFFT     = 2 ** SIZE_BUFFER;
   localparam int              CW       = SIZE_BUFFER + 1;
   localparam logic [CW-1:0]   CNT_CP   = CW'(CP_LEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(CP_LEN + NFFT - 1);
   localparam bit              BITREV   = (ORDER == "bitrev");

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_WRITING,
      BANK_FULL,
      BANK_READING
   } bank_state_t;

   bank_state_t bank_q [2];
   bank_state_t bank_d [2];

   logic [CW-1:0]          cnt_q, cnt_d, cnt_eff;
   logic                   wr_active_q, wr_active_d;
   logic                   wr_bank_q, wr_bank_d;
   logic                   old_q, old_d;
   logic                   rd_active_q, rd_active_d;
   logic                   rd_bank_q, rd_bank_d;
   logic [SIZE_BUFFER-1:0] rd_ptr_q, rd_ptr_d;
   logic                   out_bank_q, out_bank_d;
   logic                   valid_out_q, valid_out_d;
   logic                   last_out_q, last_out_d;
   logic [DATA_SIZE-1:0]   out_i_q, out_i_d;
   logic [DATA_SIZE-1:0]   out_q_q, out_q_d;
   logic [SIZE_BUFFER-1:0] index_q, index_d;
   logic                   overflow_q, overflow_d;
   logic                   wayt_q, wayt_d;

   logic                   mem_we;
   logic                   mem_wbank;
   logic [SIZE_BUFFER-1:0] mem_waddr;
   logic [2*DATA_SIZE-1:0] mem_wdata;
   logic [SIZE_BUFFER-1:0] rd_addr;
   logic [2*DATA_SIZE-1:0] rd_word;
   logic                   accept, load, pick, pick_ok;

   logic [2*DATA_SIZE-1:0] bank_mem [2][NFFT];

   function automatic logic [SIZE_BUFFER-1:0] bit_rev(input logic [SIZE_BUFFER-1:0] a);
      for (int i = 0; i < SIZE_BUFFER; i++) begin
         bit_rev[i] = a[SIZE_BUFFER-1-i];
      end
   endfunction

   always_ff @(posedge clk) begin
      if (mem_we) begin
         bank_mem[mem_wbank][mem_waddr] <= mem_wdata;
      end
   end

   assign rd_addr = BITREV ? bit_rev(rd_ptr_q) : rd_ptr_q;
   assign rd_word = bank_mem[rd_bank_q][rd_addr];
   assign accept  = valid_out_q & bus.flag_ready_recive;
   assign load    = rd_active_q & (~valid_out_q | accept);

   // Bank state only moves WRITING->FULL/EMPTY on the writer side and
   // FULL->READING->EMPTY on the reader side, so the two never collide.
   always_comb begin
      cnt_d       = cnt_q;
      wr_active_d = wr_active_q;
      wr_bank_d   = wr_bank_q;
      old_d       = old_q;
      bank_d      = bank_q;
      overflow_d  = 1'b0;
      mem_we      = 1'b0;
      mem_wbank   = wr_bank_q;
      mem_waddr   = '0;
      mem_wdata   = {bus.data_in_i, bus.data_in_q};
      cnt_eff     = bus.sof ? '0 : cnt_q;

      if (bus.valid) begin
         cnt_d = (cnt_eff == CNT_LAST) ? '0 : cnt_eff + 1'b1;
         if (bus.sof && wr_active_q) begin
            bank_d[wr_bank_q] = BANK_EMPTY;
            wr_active_d       = 1'b0;
         end
         if (cnt_eff == CNT_CP) begin
            if (bank_q[0] == BANK_EMPTY) begin
               wr_active_d = 1'b1;
               wr_bank_d   = 1'b0;
            end else if (bank_q[1] == BANK_EMPTY) begin
               wr_active_d = 1'b1;
               wr_bank_d   = 1'b1;
            end else begin
               wr_active_d = 1'b0;
               overflow_d  = 1'b1;
            end
            if (wr_active_d) begin
               bank_d[wr_bank_d] = BANK_WRITING;
            end
         end
         if (wr_active_d) begin
            mem_we    = 1'b1;
            mem_wbank = wr_bank_d;
            mem_waddr = SIZE_BUFFER'(cnt_eff - CNT_CP);
            if (cnt_eff == CNT_LAST) begin
               bank_d[wr_bank_d] = BANK_FULL;
               wr_active_d       = 1'b0;
               old_d = (bank_q[~wr_bank_d] == BANK_FULL) ? ~wr_bank_d : wr_bank_d;
            end
         end
      end

      rd_active_d = rd_active_q;
      rd_bank_d   = rd_bank_q;
      rd_ptr_d    = rd_ptr_q;
      out_bank_d  = out_bank_q;
      valid_out_d = valid_out_q;
      last_out_d  = last_out_q;
      out_i_d     = out_i_q;
      out_q_d     = out_q_q;
      index_d     = index_q;
      pick        = 1'b0;
      pick_ok     = 1'b0;

      if (accept && last_out_q) begin
         bank_d[out_bank_q] = BANK_EMPTY;
      end
      if (load) begin
         {out_i_d, out_q_d} = rd_word;
         index_d     = rd_addr;
         last_out_d  = &rd_ptr_q;
         valid_out_d = 1'b1;
         out_bank_d  = rd_bank_q;
         rd_ptr_d    = rd_ptr_q + 1'b1;
         if (&rd_ptr_q) begin
            rd_active_d = 1'b0;
         end
      end else if (accept) begin
         valid_out_d = 1'b0;
         last_out_d  = 1'b0;
      end

      // Claim the next bank while the final element of the current one is
      // still waiting, so consecutive banks stream without a bubble.
      if (!rd_active_d) begin
         if (bank_q[0] == BANK_FULL && bank_q[1] == BANK_FULL) begin
            pick    = old_q;
            pick_ok = 1'b1;
         end else if (bank_q[0] == BANK_FULL) begin
            pick    = 1'b0;
            pick_ok = 1'b1;
         end else if (bank_q[1] == BANK_FULL) begin
            pick    = 1'b1;
            pick_ok = 1'b1;
         end
         if (pick_ok) begin
            rd_active_d  = 1'b1;
            rd_bank_d    = pick;
            rd_ptr_d     = '0;
            bank_d[pick] = BANK_READING;
         end
      end

      wayt_d = (bank_d[0] == BANK_EMPTY) | (bank_d[1] == BANK_EMPTY);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bank_q[0]   <= BANK_EMPTY;
         bank_q[1]   <= BANK_EMPTY;
         cnt_q       <= '0;
         wr_active_q <= 1'b0;
         wr_bank_q   <= 1'b0;
         old_q       <= 1'b0;
         rd_active_q <= 1'b0;
         rd_bank_q   <= 1'b0;
         rd_ptr_q    <= '0;
         out_bank_q  <= 1'b0;
         valid_out_q <= 1'b0;
         last_out_q  <= 1'b0;
         out_i_q     <= '0;
         out_q_q     <= '0;
         index_q     <= '0;
         overflow_q  <= 1'b0;
         wayt_q      <= 1'b1;
      end else begin
         bank_q      <= bank_d;
         cnt_q       <= cnt_d;
         wr_active_q <= wr_active_d;
         wr_bank_q   <= wr_bank_d;
         old_q       <= old_d;
         rd_active_q <= rd_active_d;
         rd_bank_q   <= rd_bank_d;
         rd_ptr_q    <= rd_ptr_d;
         out_bank_q  <= out_bank_d;
         valid_out_q <= valid_out_d;
         last_out_q  <= last_out_d;
         out_i_q     <= out_i_d;
         out_q_q     <= out_q_d;
         index_q     <= index_d;
         overflow_q  <= overflow_d;
         wayt_q      <= wayt_d;
      end
   end

   assign bus.data_out_i     = out_i_q;
   assign bus.data_out_q     = out_q_q;
   assign bus.valid_out      = valid_out_q;
   assign bus.last_out       = last_out_q;
   assign bus.index_out      = index_q;
   assign bus.overflow       = overflow_q;
   assign bus.flag_wayt_data = wayt_q;
endmodule

// File: tb/tb_ofdm_fft_frame_buffer.sv
// Directed bench for ofdm_fft_frame_buffer with NFFT=8, CP_LEN=2: a natural-order
// and a bit-reversed instance receive the same input stream.
module tb_ofdm_fft_frame_buffer;
   localparam int SB = 3;
   localparam int DW = 16;

   logic          clk   = 1'b0;
   logic          reset = 1'b0;
   logic          valid = 1'b0;
   logic          sof   = 1'b0;
   logic          ready = 1'b0;
   logic [DW-1:0] din_i = '0;
   logic [DW-1:0] din_q = '0;

   int total = 0;
   int bad   = 0;
   int got_i[$], got_q[$], got_idx[$], got_last[$];
   int gotb_i[$], gotb_idx[$];
   bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   ofdm_fft_frame_buffer_if #(.SIZE_BUFFER(SB), .DATA_SIZE(DW)) bus_n ();
   ofdm_fft_frame_buffer_if #(.SIZE_BUFFER(SB), .DATA_SIZE(DW)) bus_b ();

   assign bus_n.valid             = valid;
   assign bus_n.sof               = sof;
   assign bus_n.data_in_i         = din_i;
   assign bus_n.data_in_q         = din_q;
   assign bus_n.flag_ready_recive = ready;
   assign bus_b.valid             = valid;
   assign bus_b.sof               = sof;
   assign bus_b.data_in_i         = din_i;
   assign bus_b.data_in_q         = din_q;
   assign bus_b.flag_ready_recive = ready;

   ofdm_fft_frame_buffer #(.SIZE_BUFFER(SB), .DATA_SIZE(DW), .CP_LEN(2), .ORDER("natural"))
      dut_n (.clk(clk), .reset(reset), .bus(bus_n));
   ofdm_fft_frame_buffer #(.SIZE_BUFFER(SB), .DATA_SIZE(DW), .CP_LEN(2), .ORDER("bitrev"))
      dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   task automatic apply_reset();
      valid = 1'b0;
      sof   = 1'b0;
      ready = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic send_sample(input bit s, input int i, input int q);
      valid = 1'b1;
      sof   = s;
      din_i = DW'(i);
      din_q = DW'(q);
      @(posedge clk);
      #1;
      valid = 1'b0;
      sof   = 1'b0;
   endtask

   // Ten consecutive samples (2 CP + 8 data), sof on the first; Q = I + 100.
   task automatic send_symbol(input int base);
      for (int n = 0; n < 10; n++) begin
         send_sample(n == 0, base + n, base + n + 100);
      end
   endtask

   task automatic collect(input int cycles);
      got_i.delete(); got_q.delete(); got_idx.delete(); got_last.delete();
      gotb_i.delete(); gotb_idx.delete();
      for (int c = 0; c < cycles; c++) begin
         if (bus_n.valid_out && ready) begin
            got_i.push_back(int'(bus_n.data_out_i));
            got_q.push_back(int'(bus_n.data_out_q));
            got_idx.push_back(int'(bus_n.index_out));
            got_last.push_back(int'(bus_n.last_out));
         end
         if (bus_b.valid_out && ready) begin
            gotb_i.push_back(int'(bus_b.data_out_i));
            gotb_idx.push_back(int'(bus_b.index_out));
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      total++;
      if (bus_n.valid_out !== 1'b0 || bus_n.last_out !== 1'b0 || bus_n.overflow !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags: valid=%b last=%b ovf=%b want 0 0 0",
                  bus_n.valid_out, bus_n.last_out, bus_n.overflow);
      end
      total++;
      if (bus_n.data_out_i !== '0 || bus_n.data_out_q !== '0 || bus_n.index_out !== '0) begin
         bad++;
         $display("[TB] FAIL reset_data: i=%0d q=%0d idx=%0d want 0 0 0",
                  bus_n.data_out_i, bus_n.data_out_q, bus_n.index_out);
      end
      total++;
      if (bus_n.flag_wayt_data !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_wayt: got %b want 1", bus_n.flag_wayt_data);
      end
      apply_reset();
   endtask

   task automatic test_natural();
      apply_reset();
      ready = 1'b1;
      send_symbol(0);
      total++;
      if (bus_n.valid_out !== 1'b0) begin
         bad++;
         $display("[TB] FAIL nat_lat_T: valid_out=%b want 0", bus_n.valid_out);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus_n.valid_out !== 1'b0) begin
         bad++;
         $display("[TB] FAIL nat_lat_T1: valid_out=%b want 0", bus_n.valid_out);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus_n.valid_out !== 1'b1 || bus_n.data_out_i !== DW'(2)) begin
         bad++;
         $display("[TB] FAIL nat_lat_T2: valid_out=%b i=%0d want 1 2",
                  bus_n.valid_out, bus_n.data_out_i);
      end
      collect(12);
      total++;
      if (got_i.size() != 8) begin
         bad++;
         $display("[TB] FAIL nat_count: got %0d want 8", got_i.size());
      end
      for (int j = 0; j < 8; j++) begin
         total++;
         if (j >= got_i.size() || got_i[j] != 2 + j || got_q[j] != 102 + j ||
             got_idx[j] != j || got_last[j] != int'(j == 7)) begin
            bad++;
            $display("[TB] FAIL nat_elem%0d: got i=%0d q=%0d idx=%0d last=%0d want %0d %0d %0d %0d",
                     j, (j < got_i.size()) ? got_i[j] : -1, (j < got_q.size()) ? got_q[j] : -1,
                     (j < got_idx.size()) ? got_idx[j] : -1, (j < got_last.size()) ? got_last[j] : -1,
                     2 + j, 102 + j, j, int'(j == 7));
         end
      end
      total++;
      if (bus_n.valid_out !== 1'b0 || bus_n.flag_wayt_data !== 1'b1) begin
         bad++;
         $display("[TB] FAIL nat_idle: valid=%b wayt=%b want 0 1", bus_n.valid_out, bus_n.flag_wayt_data);
      end
   endtask

   task automatic test_bitrev();
      int exp_i [8] = '{2, 6, 4, 8, 3, 7, 5, 9};
      int exp_x [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      apply_reset();
      ready = 1'b1;
      send_symbol(0);
      collect(14);
      total++;
      if (gotb_i.size() != 8) begin
         bad++;
         $display("[TB] FAIL brev_count: got %0d want 8", gotb_i.size());
      end
      for (int j = 0; j < 8; j++) begin
         total++;
         if (j >= gotb_i.size() || gotb_i[j] != exp_i[j] || gotb_idx[j] != exp_x[j]) begin
            bad++;
            $display("[TB] FAIL brev_elem%0d: got i=%0d idx=%0d want %0d %0d", j,
                     (j < gotb_i.size()) ? gotb_i[j] : -1, (j < gotb_idx.size()) ? gotb_idx[j] : -1,
                     exp_i[j], exp_x[j]);
         end
      end
   endtask

   task automatic test_overflow();
      int ovf_seen = 0;
      int exp_v;
      apply_reset();
      for (int s = 0; s < 3; s++) begin
         for (int n = 0; n < 10; n++) begin
            send_sample(n == 0, 16 * s + n, 16 * s + n + 100);
            if (bus_n.overflow === 1'b1) ovf_seen++;
            total++;
            if (bus_n.overflow !== 1'(s == 2 && n == 2)) begin
               bad++;
               $display("[TB] FAIL ovf_s%0d_n%0d: got %b want %b", s, n, bus_n.overflow, (s == 2 && n == 2));
            end
         end
         if (s == 0) begin
            total++;
            if (bus_n.flag_wayt_data !== 1'b1) begin
               bad++;
               $display("[TB] FAIL ovf_wayt_sym1: got %b want 1", bus_n.flag_wayt_data);
            end
         end
         if (s == 1) begin
            total++;
            if (bus_n.flag_wayt_data !== 1'b0) begin
               bad++;
               $display("[TB] FAIL ovf_wayt_sym2: got %b want 0", bus_n.flag_wayt_data);
            end
         end
      end
      total++;
      if (ovf_seen != 1) begin
         bad++;
         $display("[TB] FAIL ovf_pulses: got %0d want 1", ovf_seen);
      end
      ready = 1'b1;
      collect(30);
      total++;
      if (got_i.size() != 16) begin
         bad++;
         $display("[TB] FAIL ovf_count: got %0d want 16", got_i.size());
      end
      for (int j = 0; j < 16; j++) begin
         exp_v = (j < 8) ? 2 + j : 18 + (j - 8);
         total++;
         if (j >= got_i.size() || got_i[j] != exp_v || got_q[j] != exp_v + 100 || got_idx[j] != j % 8) begin
            bad++;
            $display("[TB] FAIL ovf_elem%0d: got i=%0d idx=%0d want %0d %0d", j,
                     (j < got_i.size()) ? got_i[j] : -1, (j < got_idx.size()) ? got_idx[j] : -1,
                     exp_v, j % 8);
         end
      end
   endtask

   task automatic test_back_pressure();
      int count = 0;
      apply_reset();
      send_symbol(50);
      for (int k = 0; k < 60 && count < 8; k++) begin
         ready = pat[k % 4];
         if (bus_n.valid_out) begin
            total++;
            if (bus_n.data_out_i !== DW'(52 + count) || bus_n.index_out !== SB'(count) ||
                bus_n.last_out !== 1'(count == 7)) begin
               bad++;
               $display("[TB] FAIL bp_k%0d: got i=%0d idx=%0d last=%b want %0d %0d %b", k,
                        bus_n.data_out_i, bus_n.index_out, bus_n.last_out, 52 + count, count, (count == 7));
            end
            if (ready) count++;
         end
         @(posedge clk);
         #1;
      end
      ready = 1'b0;
      total++;
      if (count != 8 || bus_n.valid_out !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bp_count: got %0d valid=%b want 8 0", count, bus_n.valid_out);
      end
   endtask

   task automatic test_sof_abort();
      apply_reset();
      ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         send_sample(n == 0, 70 + n, 170 + n);
      end
      send_symbol(80);
      collect(20);
      total++;
      if (got_i.size() != 8) begin
         bad++;
         $display("[TB] FAIL sof_count: got %0d want 8", got_i.size());
      end
      for (int j = 0; j < 8; j++) begin
         total++;
         if (j >= got_i.size() || got_i[j] != 82 + j || got_idx[j] != j) begin
            bad++;
            $display("[TB] FAIL sof_elem%0d: got i=%0d want %0d", j, (j < got_i.size()) ? got_i[j] : -1, 82 + j);
         end
      end
   endtask

   task automatic test_reset_midread();
      bit found = 1'b0;
      apply_reset();
      ready = 1'b1;
      send_symbol(30);
      for (int c = 0; c < 20 && !found; c++) begin
         if (bus_n.valid_out === 1'b1 && bus_n.index_out === SB'(3)) found = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("[TB] FAIL mid_find: element 3 seen=%b want 1", found);
      end
      reset = 1'b1;
      #1;
      total++;
      if (bus_n.valid_out !== 1'b0 || bus_n.data_out_i !== '0 || bus_n.data_out_q !== '0 ||
          bus_n.index_out !== '0 || bus_n.last_out !== 1'b0 || bus_n.flag_wayt_data !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mid_async: valid=%b i=%0d q=%0d idx=%0d last=%b wayt=%b want 0 0 0 0 0 1",
                  bus_n.valid_out, bus_n.data_out_i, bus_n.data_out_q, bus_n.index_out,
                  bus_n.last_out, bus_n.flag_wayt_data);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      send_symbol(40);
      collect(14);
      total++;
      if (got_i.size() != 8) begin
         bad++;
         $display("[TB] FAIL mid_count: got %0d want 8", got_i.size());
      end
      for (int j = 0; j < 8; j++) begin
         total++;
         if (j >= got_i.size() || got_i[j] != 42 + j || got_idx[j] != j) begin
            bad++;
            $display("[TB] FAIL mid_elem%0d: got i=%0d want %0d", j, (j < got_i.size()) ? got_i[j] : -1, 42 + j);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_natural();
      test_bitrev();
      test_overflow();
      test_back_pressure();
      test_sof_abort();
      test_reset_midread();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
